mem_io_bridge: RTL and testbench

MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

---
 rtl/mio_pkg.sv | 22 ++
 rtl/mio_addr_decode.sv | 30 +++
 rtl/mem_io_bridge.sv | 141 ++++++++++++++
 tb/tb_mem_io_bridge.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - shared address map, FSM encoding and target type for mem_io_bridge
package mio_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    localparam logic [3:0]  RAM_REGION = 4'h0;
    localparam logic [31:0] LED_ADDR   = 32'hE000_0000;
    localparam logic [31:0] SW_ADDR    = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR   = 32'hF000_0004;

    typedef enum logic [2:0] {
        TGT_NONE,
        TGT_RAM,
        TGT_LED,
        TGT_SW,
        TGT_CNT
    } mio_target_e;

endpackage

// File: rtl/mio_addr_decode.sv
// rtl/mio_addr_decode.sv - combinational address/request-type decoder for mem_io_bridge
module mio_addr_decode
    import mio_pkg::*;
(
    input  logic [31:0]  addr,
    input  logic         is_read,
    input  logic         is_write,
    output mio_target_e  target,
    output logic         legal
);

    // Map the byte address to a target, then reject ambiguous requests,
    // unmapped addresses and writes to read-only registers.
    always_comb begin
        target = TGT_NONE;
        if (addr[31:28] == RAM_REGION) begin
            target = TGT_RAM;
        end else if (addr == LED_ADDR) begin
            target = TGT_LED;
        end else if (addr == SW_ADDR) begin
            target = TGT_SW;
        end else if (addr == CNT_ADDR) begin
            target = TGT_CNT;
        end
        legal = (is_read ^ is_write)
              && (target != TGT_NONE)
              && !(is_write && ((target == TGT_SW) || (target == TGT_CNT)));
    end

endmodule

// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - CPU to RAM / memory-mapped IO bridge with handshake FSM
module mem_io_bridge
    import mio_pkg::*;
#(
    parameter int RAM_LAT = 1,
    parameter int RAM_AW  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              CPU_MIO,
    input  logic [31:0]       addr,
    input  logic [31:0]       data_from_cpu,
    output logic [31:0]       data_to_cpu,
    output logic              MIO_ready,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [7:0]        led_out,
    input  logic [7:0]        sw_in
);

    // Index of the final RD_WAIT cycle; with zero latency RD_WAIT is skipped.
    localparam logic [2:0] LAST_WAIT = (RAM_LAT == 0) ? 3'd0 : 3'(RAM_LAT - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [7:0]  led_q, led_d;
    logic [31:0] cnt_q, cnt_d;
    logic        bypass_q, bypass_d;

    mio_target_e target;
    logic        legal;
    logic        req;

    mio_addr_decode u_decode (
        .addr     (addr),
        .is_read  (MemRead),
        .is_write (MemWrite),
        .target   (target),
        .legal    (legal)
    );

    assign req      = CPU_MIO && (MemRead || MemWrite);
    assign ram_addr = addr[RAM_AW+1:2];
    assign ram_din  = data_from_cpu;
    assign cnt_d    = cnt_q + 32'd1;

    assign MIO_ready   = (state_q == ST_ACK);
    assign bus_err     = (state_q == ST_ACK) && err_q;
    // Zero-latency RAM reads return ram_dout straight through during ACK.
    assign data_to_cpu = bypass_q ? ram_dout : data_q;
    assign led_out     = led_q;

    // Next-state logic: requests are sampled only in IDLE; the write strobe is
    // confined to the acceptance cycle and suppressed while reset is asserted.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        data_d   = data_q;
        err_d    = err_q;
        led_d    = led_q;
        bypass_d = 1'b0;
        ram_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    err_d   = !legal;
                    data_d  = 32'd0;
                    state_d = ST_ACK;
                    if (legal) begin
                        case (target)
                            TGT_RAM: begin
                                if (MemWrite) begin
                                    ram_we = !reset;
                                end else if (RAM_LAT == 0) begin
                                    bypass_d = 1'b1;
                                end else begin
                                    wait_d  = 3'd0;
                                    state_d = ST_RD_WAIT;
                                end
                            end
                            TGT_LED: begin
                                if (MemWrite) begin
                                    led_d = data_from_cpu[7:0];
                                end else begin
                                    data_d = {24'd0, led_q};
                                end
                            end
                            TGT_SW:  data_d = {24'd0, sw_in};
                            TGT_CNT: data_d = cnt_q;
                            default: data_d = 32'd0;
                        endcase
                    end
                end
            end
            ST_RD_WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    data_d  = ram_dout;
                    state_d = ST_ACK;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ST_ACK: state_d = ST_HOLD;
            ST_HOLD: begin
                if (!(MemRead || MemWrite) || !CPU_MIO) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wait_q   <= 3'd0;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
            led_q    <= 8'd0;
            cnt_q    <= 32'd0;
            bypass_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            data_q   <= data_d;
            err_q    <= err_d;
            led_q    <= led_d;
            cnt_q    <= cnt_d;
            bypass_q <= bypass_d;
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - scoreboard testbench for mem_io_bridge
module tb_mem_io_bridge;
    import mio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, CPU_MIO;
    logic [31:0] addr, data_from_cpu, data_to_cpu;
    logic        MIO_ready, bus_err;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_din, ram_dout;
    logic [7:0]  led_out, sw_in;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic        chk_data;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acks     = 0;
    int   we_count = 0;

    mem_io_bridge #(.RAM_LAT(1), .RAM_AW(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .CPU_MIO       (CPU_MIO),
        .addr          (addr),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu),
        .MIO_ready     (MIO_ready),
        .bus_err       (bus_err),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout),
        .led_out       (led_out),
        .sw_in         (sw_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write strobes sampled mid-cycle, after the negedge+1 input drive.
    always @(negedge clk) begin
        #3;
        if (ram_we) we_count++;
    end

    // Completion monitor: pop the scoreboard on every MIO_ready pulse.
    always @(negedge clk) begin
        if (bus_err && !MIO_ready) check("err_without_ready", 32'd1, 32'd0);
        if (MIO_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_data) check("rd_data", data_to_cpu, e.data);
                check("bus_err", 32'(bus_err), 32'(e.err));
                check("latency", 32'(cyc - e.cyc), 32'(e.lat));
            end
            acks++;
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic chk_data,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input logic exp_we);
        int   start_acks;
        int   start_we;
        logic done;
        exp_t e;
        @(negedge clk);
        #1;
        start_acks    = acks;
        start_we      = we_count;
        MemRead       = rd;
        MemWrite      = wr;
        CPU_MIO       = 1'b1;
        addr          = a;
        data_from_cpu = d;
        e.chk_data = chk_data;
        e.data     = exp_data;
        e.err      = exp_err;
        e.lat      = exp_lat;
        e.cyc      = cyc;
        sb.push_back(e);
        #2;
        check("we_at_N", 32'(ram_we), 32'(exp_we));
        if (exp_we) begin
            check("ram_addr", 32'(ram_addr), {22'd0, a[11:2]});
            check("ram_din", ram_din, d);
        end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            #2;
            if (acks != start_acks) done = 1'b1;
        end
        if (!done) check("ack_timeout", 32'd0, 32'd1);
        // Keep the request held: no second completion or write may follow.
        repeat (2) @(negedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        CPU_MIO  = 1'b0;
        @(negedge clk);
        #4;
        check("we_count", 32'(we_count - start_we), 32'(exp_we));
    endtask

    initial begin
        reset = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; CPU_MIO = 1'b0;
        addr = 32'd0; data_from_cpu = 32'd0; sw_in = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(MIO_ready), 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_data", data_to_cpu, 32'd0);
        check("rst_led", 32'(led_out), 32'd0);
        check("rst_cnt", dut.cnt_q, 32'd0);
        #1 reset = 1'b0;

        // RAM write then read back
        do_req(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, 1, 1'b1);
        do_req(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2, 1'b0);
        // Top RAM word
        do_req(1'b0, 1'b1, 32'h0000_0FFC, 32'h1234_5678, 1'b0, 32'd0, 1'b0, 1, 1'b1);
        do_req(1'b1, 1'b0, 32'h0000_0FFC, 32'd0, 1'b1, 32'h1234_5678, 1'b0, 2, 1'b0);

        // LED write / read, switch read
        do_req(1'b0, 1'b1, LED_ADDR, 32'h0000_00A5, 1'b0, 32'd0, 1'b0, 1, 1'b0);
        check("led_after_write", 32'(led_out), 32'h0000_00A5);
        do_req(1'b1, 1'b0, LED_ADDR, 32'd0, 1'b1, 32'h0000_00A5, 1'b0, 1, 1'b0);
        sw_in = 8'h3C;
        do_req(1'b1, 1'b0, SW_ADDR, 32'd0, 1'b1, 32'h0000_003C, 1'b0, 1, 1'b0);

        // Illegal accesses
        do_req(1'b0, 1'b1, SW_ADDR, 32'h0000_0077, 1'b1, 32'd0, 1'b1, 1, 1'b0);
        check("led_unchanged", 32'(led_out), 32'h0000_00A5);
        do_req(1'b1, 1'b1, 32'h0000_0020, 32'h5555_5555, 1'b1, 32'd0, 1'b1, 1, 1'b0);
        do_req(1'b1, 1'b0, 32'h4000_0000, 32'd0, 1'b1, 32'd0, 1'b1, 1, 1'b0);
        do_req(1'b0, 1'b1, CNT_ADDR, 32'h0000_0001, 1'b1, 32'd0, 1'b1, 1, 1'b0);

        // Counter wrap, then read: sampled value is one cycle past zero
        @(negedge clk);
        force dut.cnt_d = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cnt_d;
        check("cnt_forced", dut.cnt_q, 32'hFFFF_FFFF);
        @(negedge clk);
        check("cnt_wrap", dut.cnt_q, 32'd0);
        do_req(1'b1, 1'b0, CNT_ADDR, 32'd0, 1'b1, 32'd1, 1'b0, 1, 1'b0);

        // Reset while in RD_WAIT aborts the read
        @(negedge clk);
        #1;
        MemRead = 1'b1; CPU_MIO = 1'b1; addr = 32'h0000_0010;
        @(negedge clk);
        check("in_rd_wait", 32'(dut.state_q), 32'(ST_RD_WAIT));
        #1 reset = 1'b1;
        @(negedge clk);
        check("idle_after_rst", 32'(dut.state_q), 32'(ST_IDLE));
        check("no_ready_rst", 32'(MIO_ready), 32'd0);
        #1;
        reset = 1'b0; MemRead = 1'b0; CPU_MIO = 1'b0;
        repeat (2) @(negedge clk);
        do_req(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
